fill_valve_arbiter: RTL and testbench
=====================================

// Module: fill_valve_arbiter
// PURPOSE
//  - Shares one building water inlet valve among N_MACHINES washing-machine controllers.
//  - Each controller's fill-valve request (fill_req[i]) enters a round-robin arbiter.
//  - Exactly one machine is granted the shared valve at a time; the grant is held until
//    that machine reports filled[i] or withdraws its request.
//  - After each fill the valve stays closed for a settle gap (water-hammer protection).
// PARAMETERS
//  - N_MACHINES       4     number of requesting machine controllers (2..16)
//  - MAX_FILL_CYCLES  1024  watchdog limit, clk cycles per grant (used only with FILL_WATCHDOG_EN)
//  - SETTLE_CYCLES    8     valve-closed gap after every grant ends (>=1)
// PORTS
//  - clk         in   1                  system clock, rising edge
//  - reset       in   1                  asynchronous, active-low reset
//  - fill_req    in   N_MACHINES         per-machine fill request (level)
//  - filled      in   N_MACHINES         per-machine level sensor, 1 = tub full
//  - fault_clr   in   N_MACHINES         per-machine pulse, clears fill_fault[i]
//  - grant       out  N_MACHINES         one-hot grant; all 0 when no machine is served
//  - grant_id    out  $clog2(N_MACHINES) index of the granted machine; 0 when idle
//  - valve_open  out  1                  drives the shared inlet valve
//  - busy        out  1                  1 in FILL or SETTLE
//  - fill_fault  out  N_MACHINES         sticky per-machine watchdog fault
// BEHAVIOUR
//  - reset (reset=0, async): state=IDLE; grant, grant_id, valve_open, busy, fill_fault all 0.
//    rr_ptr = N_MACHINES-1, so machine 0 wins first. Reset mid-FILL closes the valve immediately.
//  - All outputs are registered. eligible = fill_req & ~fill_fault.
//  - IDLE:
//    - If eligible != 0 at edge k, pick the first set bit searching rr_ptr+1 upward, wrapping at N_MACHINES.
//    - After edge k: state=FILL, grant[g]=1, grant_id=g, valve_open=1, busy=1, fill_cnt=0.
//    - Grant latency is 1 cycle from the request.
//  - FILL: fill_cnt increments every cycle. Exit to SETTLE at the next edge when any of:
//    - filled[g]=1 (normal completion)
//    - fill_req[g]=0 (withdrawal)
//    - watchdog expiry
//    On exit: grant=0, valve_open=0, rr_ptr=g, settle_cnt=0.
//    Requests from other machines do not pre-empt the current grant.
//  - SETTLE: valve closed, busy=1 for exactly SETTLE_CYCLES cycles, then IDLE.
//    Arbitration resumes in IDLE, so back-to-back grants are separated by SETTLE_CYCLES+1 valve-closed cycles.
//  - Simultaneous events:
//    - filled[g]=1 in the same cycle as watchdog expiry: completion wins, no fault.
//    - fault set and fault_clr[g] in the same cycle: set wins.
//    - filled[i]=1 while requesting in IDLE: still granted. Exit happens on the first FILL cycle (1-cycle grant).
//  - Width: fill_cnt is $clog2(MAX_FILL_CYCLES+1) bits and saturates; it never wraps.
//  - Illegal state encodings return to IDLE with all outputs 0.
// CONFIGURATION
//  - Macro FILL_WATCHDOG_EN.
//  - Defined:
//    - fill_cnt reaching MAX_FILL_CYCLES in FILL (without filled) sets fill_fault[g] sticky and ends the grant.
//    - A faulted machine is excluded from arbitration until fault_clr[g] pulses.
//  - Undefined:
//    - No fill_cnt or watchdog logic.
//    - fill_fault is tied to 0 and fault_clr is ignored.
//    - A grant ends only on filled[g] or withdrawal.
// TESTING
//  1. Reset, then fill_req=4'b0001; filled[0]=1 after 20 cycles.
//     -> grant=0001 one cycle after the request; valve_open high 20 cycles; 8 cycles closed; then IDLE.
//  2. fill_req=4'b1111 held, each filled pulsed 5 cycles after its grant.
//     -> grant order 0,1,2,3,0; valve never open for two machines at once.
//  3. Machine 2 granted; fill_req=4'b0100 drops mid-FILL.
//     -> valve_open=0 next edge; SETTLE entered; rr_ptr=2; next grant goes to machine 3 if it requests.
//  4. (FILL_WATCHDOG_EN, MAX_FILL_CYCLES=16) Machine 1 granted, filled never asserted.
//     -> fill_fault=0010 and grant cleared after 16 cycles; machine 1 skipped until fault_clr[1].
//  5. (FILL_WATCHDOG_EN) filled[1] rises on the expiry cycle.
//     -> fill_fault stays 0; normal SETTLE.
//  6. reset low mid-FILL.
//     -> valve_open=0 and grant=0 immediately; after release, machine 0 is granted first.

Source files
------------

// File: rtl/fill_valve_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fill_valve_arbiter: round-robin sharing of one inlet valve, settle gap.  |
// | Optional watchdog: FILL_WATCHDOG_EN.  Revision 1.0                       |
// +--------------------------------------------------------------------------+
module fill_valve_arbiter #(
  parameter int N_MACHINES      = 4,
  parameter int MAX_FILL_CYCLES = 1024,
  parameter int SETTLE_CYCLES   = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_MACHINES-1:0]         fill_req_i,
  input  logic [N_MACHINES-1:0]         filled_i,
  input  logic [N_MACHINES-1:0]         fault_clr_i,
  output logic [N_MACHINES-1:0]         grant_o,
  output logic [$clog2(N_MACHINES)-1:0] grant_id_o,
  output logic                          valve_open_o,
  output logic                          busy_o,
  output logic [N_MACHINES-1:0]         fill_fault_o
);

  localparam int ID_W = $clog2(N_MACHINES);
  localparam int SW   = $clog2(SETTLE_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FILL   = 2'd1,
    S_SETTLE = 2'd2
  } state_t;

  state_t                state_q;
  logic [N_MACHINES-1:0] grant_q;
  logic [ID_W-1:0]       grant_id_q;
  logic                  valve_q;
  logic                  busy_q;
  logic [ID_W-1:0]       rr_ptr_q;
  logic [SW-1:0]         settle_cnt_q;
  logic [N_MACHINES-1:0] fill_fault_q;

  logic [N_MACHINES-1:0] w_eligible;
  logic [ID_W-1:0]       w_idx;
  logic [ID_W-1:0]       w_pick_id;
  logic                  w_found;
  logic                  w_expire;
  logic                  w_end;

  assign w_eligible = fill_req_i & ~fill_fault_q;

  // First eligible machine strictly after rr_ptr, wrapping at N_MACHINES.
  always_comb begin
    w_idx     = '0;
    w_pick_id = '0;
    w_found   = 1'b0;
    for (int k = 1; k <= N_MACHINES; k++) begin
      w_idx = ID_W'((int'(rr_ptr_q) + k) % N_MACHINES);
      if (!w_found && w_eligible[w_idx]) begin
        w_found   = 1'b1;
        w_pick_id = w_idx;
      end
    end
  end

`ifdef FILL_WATCHDOG_EN
  localparam int CNT_W = $clog2(MAX_FILL_CYCLES + 1);

  logic [CNT_W-1:0]      fill_cnt_q;
  logic [N_MACHINES-1:0] w_fault_set;

  // Expiry is flagged on the cycle whose edge would bring fill_cnt to the limit.
  assign w_expire    = (state_q == S_FILL) && (fill_cnt_q >= CNT_W'(MAX_FILL_CYCLES - 1));
  assign w_fault_set = w_expire ? (grant_q & ~filled_i) : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_cnt_q <= '0;
    end else if (state_q != S_FILL) begin
      fill_cnt_q <= '0;
    end else if (fill_cnt_q != CNT_W'(MAX_FILL_CYCLES)) begin
      fill_cnt_q <= fill_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_fault_q <= '0;
    end else begin
      fill_fault_q <= (fill_fault_q & ~fault_clr_i) | w_fault_set;
    end
  end
`else
  logic w_unused_cfg;

  assign w_expire     = 1'b0;
  assign fill_fault_q = '0;
  assign w_unused_cfg = ^{fault_clr_i, 32'(MAX_FILL_CYCLES)};
`endif

  assign w_end = filled_i[grant_id_q] | ~fill_req_i[grant_id_q] | w_expire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      grant_id_q   <= '0;
      valve_q      <= 1'b0;
      busy_q       <= 1'b0;
      rr_ptr_q     <= ID_W'(N_MACHINES - 1);
      settle_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_found) begin
            state_q    <= S_FILL;
            grant_q    <= N_MACHINES'(1) << w_pick_id;
            grant_id_q <= w_pick_id;
            valve_q    <= 1'b1;
            busy_q     <= 1'b1;
          end else begin
            grant_q    <= '0;
            grant_id_q <= '0;
            valve_q    <= 1'b0;
            busy_q     <= 1'b0;
          end
        end
        S_FILL: begin
          if (w_end) begin
            state_q      <= S_SETTLE;
            grant_q      <= '0;
            grant_id_q   <= '0;
            valve_q      <= 1'b0;
            rr_ptr_q     <= grant_id_q;
            settle_cnt_q <= '0;
          end
        end
        S_SETTLE: begin
          if (settle_cnt_q == SW'(SETTLE_CYCLES - 1)) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          grant_q    <= '0;
          grant_id_q <= '0;
          valve_q    <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign grant_o      = grant_q;
  assign grant_id_o   = grant_id_q;
  assign valve_open_o = valve_q;
  assign busy_o       = busy_q;
  assign fill_fault_o = fill_fault_q;

endmodule
`default_nettype wire

// File: tb/tb_fill_valve_arbiter.sv
`default_nettype none
// Directed bench for fill_valve_arbiter: vector table plus multi-cycle sequences.
// Watchdog sequences are compiled when FILL_WATCHDOG_EN is defined.
module tb_fill_valve_arbiter;

  localparam int N      = 4;
  localparam int MAXF   = 16;
  localparam int SETTLE = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] fill_req = '0, filled = '0, fault_clr = '0;
  logic [3:0] grant, fill_fault;
  logic [1:0] grant_id;
  logic       valve_open, busy;

  int nvec = 0;
  int nmis = 0;

  fill_valve_arbiter #(
    .N_MACHINES(N), .MAX_FILL_CYCLES(MAXF), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .reset(reset),
    .fill_req_i(fill_req), .filled_i(filled), .fault_clr_i(fault_clr),
    .grant_o(grant), .grant_id_o(grant_id), .valve_open_o(valve_open),
    .busy_o(busy), .fill_fault_o(fill_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] req;
    logic [3:0] fil;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       b;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] req, input logic [3:0] fil, input logic [3:0] g,
                     input logic [1:0] id, input logic v, input logic b);
    vec_t t;
    t.req = req; t.fil = fil; t.g = g; t.id = id; t.v = v; t.b = b;
    tbl.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; fill_req = '0; filled = '0; fault_clr = '0;
    step(); step();
    reset = 1'b1;
  endtask

  // Steps until a grant is seen; returns the number of steps taken.
  task automatic wait_grant(input string nm, output int cyc);
    cyc = 0;
    while (grant == '0 && cyc < 200) begin
      step();
      cyc++;
    end
    if (grant == '0) chk({nm, " timeout"}, 32'd1, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int cyc;
    int n;
    logic [1:0] order [5];
    logic any_g;

    // Table: request 0, complete, settle, rr to 1, withdraw, rr to 3, 1-cycle grant.
    add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'b0001, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < SETTLE - 1; i++) add(4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'b1010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);
    add(4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < SETTLE - 1; i++) add(4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'b1000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1);
    add(4'b1000, 4'b1000, 4'b0000, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < SETTLE - 1; i++) add(4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);
    add(4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(4'b0101, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
    add(4'b0101, 4'b0001, 4'b0000, 2'd0, 1'b0, 1'b1);

    do_reset();
    chk("reset grant", 32'(grant), 32'd0);
    chk("reset grant_id", 32'(grant_id), 32'd0);
    chk("reset valve", 32'(valve_open), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset fault", 32'(fill_fault), 32'd0);

    foreach (tbl[i]) begin
      fill_req = tbl[i].req;
      filled   = tbl[i].fil;
      step();
      chk($sformatf("vec%0d grant", i), 32'(grant), 32'(tbl[i].g));
      chk($sformatf("vec%0d id", i), 32'(grant_id), 32'(tbl[i].id));
      chk($sformatf("vec%0d valve", i), 32'(valve_open), 32'(tbl[i].v));
      chk($sformatf("vec%0d busy", i), 32'(busy), 32'(tbl[i].b));
      chk($sformatf("vec%0d fault", i), 32'(fill_fault), 32'd0);
    end

    // All four request; round-robin order and the settle gap.
    do_reset();
    order[0] = 2'd0; order[1] = 2'd1; order[2] = 2'd2; order[3] = 2'd3; order[4] = 2'd0;
    filled   = '0;
    fill_req = 4'b1111;
    for (int gi = 0; gi < 5; gi++) begin
      wait_grant("rr", cyc);
      chk($sformatf("rr%0d gap", gi), 32'(cyc), (gi == 0) ? 32'd1 : 32'(SETTLE + 1));
      chk($sformatf("rr%0d id", gi), 32'(grant_id), 32'(order[gi]));
      chk($sformatf("rr%0d grant", gi), 32'(grant), 32'(4'b0001 << order[gi]));
      for (int c = 0; c < 4; c++) begin
        step();
        chk($sformatf("rr%0d hold", gi), 32'({valve_open, grant}), 32'({1'b1, 4'b0001 << order[gi]}));
      end
      filled = 4'b0001 << order[gi];
      step();
      filled = '0;
      chk($sformatf("rr%0d release", gi), 32'({valve_open, busy, grant}), 32'({1'b0, 1'b1, 4'b0000}));
    end

    // Machine 2 withdraws mid-fill; rr_ptr=2 so machine 3 beats machine 0.
    do_reset();
    fill_req = 4'b0100;
    step();
    chk("wd2 id", 32'(grant_id), 32'd2);
    step(); step();
    fill_req = 4'b0000;
    step();
    chk("wd2 drop", 32'({valve_open, busy, grant}), 32'({1'b0, 1'b1, 4'b0000}));
    fill_req = 4'b1001;
    wait_grant("wd2 next", cyc);
    chk("wd2 next grant", 32'(grant), 32'(4'b1000));

    // Asynchronous reset while machine 3 fills.
    step();
    #2 reset = 1'b0;
    #1;
    chk("async reset", 32'({valve_open, busy, grant}), 32'd0);
    step();
    reset = 1'b1;
    fill_req = 4'b1111;
    step();
    chk("post reset grant", 32'(grant), 32'(4'b0001));

`ifdef FILL_WATCHDOG_EN
    do_reset();
    fill_req = 4'b0010;
    step();
    chk("wdog grant", 32'(grant), 32'(4'b0010));
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (!valve_open) break;
      n++;
      step();
    end
    chk("wdog open cycles", 32'(n), 32'(MAXF));
    chk("wdog fault", 32'(fill_fault), 32'(4'b0010));
    chk("wdog grant clr", 32'(grant), 32'd0);
    fill_req = 4'b0011;
    wait_grant("wdog skip", cyc);
    chk("wdog skip grant", 32'(grant), 32'(4'b0001));
    filled = 4'b0001;
    step();
    filled   = '0;
    fill_req = 4'b0010;
    any_g = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      any_g = any_g | (|grant);
    end
    chk("wdog excluded", 32'(any_g), 32'd0);
    fault_clr = 4'b0010;
    step();
    fault_clr = '0;
    chk("wdog cleared", 32'(fill_fault), 32'd0);
    wait_grant("wdog regrant", cyc);
    chk("wdog regrant", 32'(grant), 32'(4'b0010));
    for (int c = 0; c < MAXF - 1; c++) step();
    chk("expiry cycle valve", 32'(valve_open), 32'd1);
    filled = 4'b0010;
    step();
    filled = '0;
    chk("expiry+filled fault", 32'(fill_fault), 32'd0);
    chk("expiry+filled settle", 32'({valve_open, busy, grant}), 32'({1'b0, 1'b1, 4'b0000}));
`else
    do_reset();
    fill_req = 4'b0010;
    step();
    for (int c = 0; c < 3 * MAXF; c++) step();
    chk("no wdog valve", 32'({valve_open, grant}), 32'({1'b1, 4'b0010}));
    chk("no wdog fault", 32'(fill_fault), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire
